xaui_rx_align_ctrl: RTL

XAUI_RX_ALIGN_CTRL -- requirements
Module: xaui_rx_align_ctrl

---
 rtl/xaui_ctrl_pkg.sv | 20 ++
 rtl/xaui_rx_align_ctrl_if.sv | 33 +++
 rtl/xaui_err_window.sv | 61 ++++++
 rtl/xaui_rx_align_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/xaui_ctrl_pkg.sv
// Shared definitions for the XAUI receive alignment controller.
// Holds the FSM state encodings, the buffer-reset pulse length, the
// comma-sync run length and a counter width helper.
package xaui_ctrl_pkg;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StWaitLock = 3'd1;
    localparam logic [2:0] StAlign    = 3'd2;
    localparam logic [2:0] StSynced   = 3'd3;
    localparam logic [2:0] StBufRst   = 3'd4;

    localparam int unsigned BufRstLen  = 4;  // cycles rxbufreset stays asserted
    localparam int unsigned SyncRunLen = 8;  // consecutive all-lane sync cycles to declare SYNCED

    // Width of a counter that must hold 0 .. n-1 (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xaui_rx_align_ctrl_if.sv
// Status/control bundle between the XAUI transceiver lanes and the
// alignment controller.
//   slave  : controller side (reads lane status, drives lane controls)
//   master : transceiver/stimulus side
// Signals: enable, rxlock[3:0], rxelecidle[3:0], rxsyncok[3:0],
//          rxcodevalid[7:0] (2 bits per lane), rxbufferr[3:0] into the
//          controller; rxencommaalign[3:0], rxbufreset[3:0], link_up,
//          state[2:0], retry_count[7:0] out of it.
interface xaui_rx_align_ctrl_if;

    logic       enable;
    logic [3:0] rxlock;
    logic [3:0] rxelecidle;
    logic [3:0] rxsyncok;
    logic [7:0] rxcodevalid;
    logic [3:0] rxbufferr;
    logic [3:0] rxencommaalign;
    logic [3:0] rxbufreset;
    logic       link_up;
    logic [2:0] state;
    logic [7:0] retry_count;

    modport slave (
        input  enable, rxlock, rxelecidle, rxsyncok, rxcodevalid, rxbufferr,
        output rxencommaalign, rxbufreset, link_up, state, retry_count
    );

    modport master (
        output enable, rxlock, rxelecidle, rxsyncok, rxcodevalid, rxbufferr,
        input  rxencommaalign, rxbufreset, link_up, state, retry_count
    );

endinterface

// File: rtl/xaui_err_window.sv
// Code-error rate monitor for the SYNCED state.
// A window counter wraps every ERR_WINDOW cycles and clears the error
// count; an error on the wrap cycle becomes the first error of the new
// window. limit_hit flags (combinationally) the cycle whose error brings
// the count to ERR_LIMIT.
// Ports: clk, rst_n  - clock, async active-low reset
//        clr         - zero both counters (takes priority over run)
//        run         - count this cycle
//        err         - this cycle carries a code error
//        limit_hit   - error limit reached in this cycle
module xaui_err_window
    import xaui_ctrl_pkg::*;
#(
    parameter int unsigned ERR_LIMIT  = 16,
    parameter int unsigned ERR_WINDOW = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    input  logic err,
    output logic limit_hit
);

    localparam int unsigned WinW = cnt_width(ERR_WINDOW);
    // One extra code point so the count can represent ERR_LIMIT itself.
    localparam int unsigned ErrW = cnt_width(ERR_LIMIT + 1);
    localparam logic [WinW-1:0] WinMax = WinW'(ERR_WINDOW - 1);
    localparam logic [ErrW-1:0] ErrLim = ErrW'(ERR_LIMIT);

    logic [WinW-1:0] win_q, win_d;
    logic [ErrW-1:0] err_q, err_d, err_next;
    logic            wrap;

    assign wrap      = (win_q == WinMax);
    assign err_next  = wrap ? ErrW'(err) : err_q + ErrW'(err);
    assign limit_hit = run && (err_next >= ErrLim);

    always_comb begin
        win_d = win_q;
        err_d = err_q;
        if (clr) begin
            win_d = '0;
            err_d = '0;
        end else if (run) begin
            win_d = wrap ? '0 : win_q + WinW'(1);
            err_d = err_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
            err_q <= '0;
        end else begin
            win_q <= win_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/xaui_rx_align_ctrl.sv
// XAUI receive alignment controller.
// Waits for all four lanes to hold CDR lock, enables comma alignment until
// every lane reports sync for SyncRunLen consecutive cycles, then monitors
// buffer errors and code-error rate, issuing a BufRstLen-cycle rx buffer
// reset on trouble. All outputs are registered.
// Ports: clk, rst_n - clock, async active-low reset
//        bus        - lane status in / lane control, link_up, state,
//                     retry_count out (see xaui_rx_align_ctrl_if)
module xaui_rx_align_ctrl
    import xaui_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_WAIT    = 1024,
    parameter int unsigned SYNC_TIMEOUT = 65536,
    parameter int unsigned ERR_LIMIT    = 16,
    parameter int unsigned ERR_WINDOW   = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    xaui_rx_align_ctrl_if.slave  bus
);

    localparam int unsigned LockW  = cnt_width(LOCK_WAIT);
    localparam int unsigned TmoW   = cnt_width(SYNC_TIMEOUT);
    localparam int unsigned RunW   = cnt_width(SyncRunLen);
    localparam int unsigned PulseW = cnt_width(BufRstLen);
    localparam logic [LockW-1:0]  LockMax  = LockW'(LOCK_WAIT - 1);
    localparam logic [TmoW-1:0]   TmoMax   = TmoW'(SYNC_TIMEOUT - 1);
    localparam logic [RunW-1:0]   RunMax   = RunW'(SyncRunLen - 1);
    localparam logic [PulseW-1:0] PulseMax = PulseW'(BufRstLen - 1);

    logic [2:0]        state_q, state_d;
    logic [LockW-1:0]  lock_q, lock_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [RunW-1:0]   run_q, run_d;
    logic [PulseW-1:0] pulse_q, pulse_d;
    logic [7:0]        retry_q, retry_d;
    logic [3:0]        comma_q, bufrst_q;
    logic              link_q;
    logic              lane_ok, err_hit, state_change;

    assign lane_ok      = (bus.rxlock == 4'hF) && (bus.rxelecidle == 4'h0);
    assign state_change = (state_d != state_q);

    xaui_err_window #(
        .ERR_LIMIT  (ERR_LIMIT),
        .ERR_WINDOW (ERR_WINDOW)
    ) u_err_window (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state_change || (state_q != StSynced)),
        .run       (state_q == StSynced),
        .err       (bus.rxcodevalid != 8'hFF),
        .limit_hit (err_hit)
    );

    always_comb begin
        state_d = state_q;
        lock_d  = '0;
        tmo_d   = '0;
        run_d   = '0;
        pulse_d = '0;
        case (state_q)
            StIdle: begin
                if (bus.enable) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (lane_ok) begin
                    if (lock_q == LockMax) state_d = StAlign;
                    else                   lock_d  = lock_q + LockW'(1);
                end
            end
            StAlign: begin
                if (bus.rxsyncok == 4'hF) begin
                    if (run_q == RunMax) state_d = StSynced;
                    else                 run_d   = run_q + RunW'(1);
                end
                // Completing the sync run wins over a coincident timeout.
                if (state_d == StAlign) begin
                    if (tmo_q == TmoMax) state_d = StBufRst;
                    else                 tmo_d   = tmo_q + TmoW'(1);
                end
            end
            StSynced: begin
                if ((bus.rxbufferr != 4'h0) || err_hit) state_d = StBufRst;
            end
            StBufRst: begin
                if (pulse_q == PulseMax) state_d = StWaitLock;
                else                     pulse_d = pulse_q + PulseW'(1);
            end
            default: state_d = StIdle;
        endcase

        if (((state_q == StAlign) || (state_q == StSynced)) && !lane_ok) state_d = StWaitLock;
        if (!bus.enable) state_d = StIdle;

        // Every state entry starts all counters from zero.
        if (state_d != state_q) begin
            lock_d  = '0;
            tmo_d   = '0;
            run_d   = '0;
            pulse_d = '0;
        end

        retry_d = retry_q;
        if ((state_d == StBufRst) && (state_q != StBufRst) && (retry_q != 8'hFF)) begin
            retry_d = retry_q + 8'd1;
        end
    end

    // Outputs are decoded from state_d so they change on the same edge as state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            lock_q   <= '0;
            tmo_q    <= '0;
            run_q    <= '0;
            pulse_q  <= '0;
            retry_q  <= '0;
            comma_q  <= '0;
            bufrst_q <= '0;
            link_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            tmo_q    <= tmo_d;
            run_q    <= run_d;
            pulse_q  <= pulse_d;
            retry_q  <= retry_d;
            comma_q  <= (state_d == StAlign)  ? 4'hF : 4'h0;
            bufrst_q <= (state_d == StBufRst) ? 4'hF : 4'h0;
            link_q   <= (state_d == StSynced);
        end
    end

    assign bus.state          = state_q;
    assign bus.rxencommaalign = comma_q;
    assign bus.rxbufreset     = bufrst_q;
    assign bus.link_up        = link_q;
    assign bus.retry_count    = retry_q;

endmodule
